// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the RV32I writeback stage.
package reg_wb_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]          rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_Q    = 2'd3
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries; exposes per-slot valid/rd
// so the top can build the pending-write mask.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  wb_entry_t             din,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output logic [DEPTH-1:0]      ent_valid,
  output logic [DEPTH-1:0][4:0] ent_rd
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_ok_s, pop_ok_s;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign head      = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  always_comb begin
    wr_ptr_d = push_ok_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + {{AW{1'b0}}, 1'b1};
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - {{AW{1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, AW'(AW'(i) - rd_ptr_q)} < count_q);
      ent_rd[i]    = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: RV32I writeback stage merging LSU loads and queued ALU results.
// Define WB_TRACE_EN to print every register write in simulation.
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_addr_lo,
  output logic            regWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] reg_wr_dat,
  output logic [31:0]     pend_mask
);

  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0]      f3,
                                               input logic [1:0]      lo,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   fmt_load = {{(XLEN-8){b[7]}}, b};
      F3_LH:   fmt_load = {{(XLEN-16){h[15]}}, h};
      F3_LW:   fmt_load = w;
      F3_LBU:  fmt_load = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  fmt_load = {{(XLEN-16){1'b0}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  logic                  q_full_s, q_empty_s, push_s, pop_s, alu_acc_s;
  wb_entry_t             q_head_s, q_din_s;
  logic [DEPTH-1:0]      ent_valid_s;
  logic [DEPTH-1:0][4:0] ent_rd_s;
  wb_src_e               src_d;
  logic                  we_d, we_q;
  logic [4:0]            rd_d, rd_q;
  logic [XLEN-1:0]       dat_d, dat_q;
  logic [31:0]           pend_s;

  assign alu_ready = !q_full_s;
  assign alu_acc_s = alu_valid && !q_full_s;
  assign q_din_s   = '{rd: alu_rd, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .din       (q_din_s),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .head      (q_head_s),
    .ent_valid (ent_valid_s),
    .ent_rd    (ent_rd_s)
  );

  // Priority LSU > queue head > ALU bypass; x0 results are consumed silently.
  always_comb begin
    src_d = SRC_NONE;
    pop_s = 1'b0;
    rd_d  = 5'd0;
    dat_d = {XLEN{1'b0}};
    if (lsu_valid) begin
      src_d = SRC_LSU;
      rd_d  = lsu_rd;
      dat_d = fmt_load(lsu_funct3, lsu_addr_lo, lsu_data);
    end else if (!q_empty_s) begin
      src_d = SRC_Q;
      pop_s = 1'b1;
      rd_d  = q_head_s.rd;
      dat_d = q_head_s.data;
    end else if (alu_acc_s) begin
      src_d = SRC_ALU;
      rd_d  = alu_rd;
      dat_d = alu_data;
    end else begin
      src_d = SRC_NONE;
    end
    we_d   = (src_d != SRC_NONE) && (rd_d != 5'd0);
    push_s = alu_acc_s && (src_d != SRC_ALU) && (alu_rd != 5'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q  <= 1'b0;
      rd_q  <= 5'd0;
      dat_q <= {XLEN{1'b0}};
    end else begin
      we_q  <= we_d;
      rd_q  <= we_d ? rd_d : 5'd0;
      dat_q <= we_d ? dat_d : {XLEN{1'b0}};
    end
  end

  assign regWrite   = we_q;
  assign rd         = rd_q;
  assign reg_wr_dat = dat_q;

  always_comb begin
    pend_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_s[i]) begin
        pend_s[ent_rd_s[i]] = 1'b1;
      end else begin
        pend_s = pend_s;
      end
    end
    if (we_q) begin
      pend_s[rd_q] = 1'b1;
    end else begin
      pend_s = pend_s;
    end
    pend_s[0] = 1'b0;
  end

  assign pend_mask = pend_s;

`ifdef WB_TRACE_EN
  wb_src_e src_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q <= SRC_NONE;
    end else begin
      src_q <= src_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && we_q) begin
      $display("WB WRITE: %h at x%0d src=%s", dat_q, rd_q,
               (src_q == SRC_ALU) ? "ALU" : (src_q == SRC_LSU) ? "LSU" : "Q");
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback with a queue-based reference model.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic        regWrite;
  logic [4:0]  rd;
  logic [31:0] reg_wr_dat;
  logic [31:0] pend_mask;

  always #5 clk = ~clk;

  reg_writeback #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .regWrite(regWrite), .rd(rd), .reg_wr_dat(reg_wr_dat), .pend_mask(pend_mask)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int          tests = 0;
  int          fails = 0;
  ent_t        mq[$];
  bit          chk_en = 1'b0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_rd = 5'd0;
  logic [31:0] exp_dat = 32'd0;
  logic [31:0] exp_pend = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                        input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (lo[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Reference: one register write per cycle chosen from LSU, then queue, then ALU.
  task automatic model_step(output bit acc);
    bit   byp;
    ent_t e;
    acc     = alu_valid && (mq.size() < DEPTH);
    byp     = 1'b0;
    exp_we  = 1'b0;
    exp_rd  = 5'd0;
    exp_dat = 32'd0;
    if (lsu_valid) begin
      if (lsu_rd != 5'd0) begin
        exp_we = 1'b1; exp_rd = lsu_rd; exp_dat = m_fmt(lsu_funct3, lsu_addr_lo, lsu_data);
      end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_we = 1'b1; exp_rd = e.rd; exp_dat = e.data;
    end else if (acc) begin
      byp = 1'b1;
      if (alu_rd != 5'd0) begin
        exp_we = 1'b1; exp_rd = alu_rd; exp_dat = alu_data;
      end
    end
    if (acc && !byp && alu_rd != 5'd0) mq.push_back('{rd: alu_rd, data: alu_data});
    exp_pend = 32'd0;
    foreach (mq[i]) exp_pend = exp_pend | (32'd1 << mq[i].rd);
    if (exp_we) exp_pend = exp_pend | (32'd1 << exp_rd);
    exp_pend = exp_pend & 32'hFFFF_FFFE;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("regWrite", {31'd0, regWrite}, {31'd0, exp_we});
      if (exp_we) begin
        chk("rd", {27'd0, rd}, {27'd0, exp_rd});
        chk("reg_wr_dat", reg_wr_dat, exp_dat);
      end
      chk("pend_mask", pend_mask, exp_pend);
      chk("alu_ready", {31'd0, alu_ready}, {31'd0, mq.size() < DEPTH});
    end
  end

  // Called at negedge+1; applies inputs for one clock and returns after the next negedge.
  task automatic step(input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [2:0] f3, input logic [1:0] lo,
                      input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      output bit acc);
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; lsu_funct3 = f3; lsu_addr_lo = lo;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    model_step(acc);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bit acc;
    step(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0, 32'd0, acc);
  endtask

  logic [2:0]  t_f3 [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
  logic [1:0]  t_lo [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
  logic [31:0] t_exp[4] = '{32'hFFFF_FFF0, 32'h0000_0080, 32'hFFFF_8070, 32'h0000_F0FF};
  int          seq_exp[10] = '{10, 11, 12, 13, 1, 2, 3, 4, 5, 6};

  initial begin
    bit          acc, have;
    int          ai;
    int          got[$];
    logic [4:0]  r_ard;
    logic [31:0] r_ad;
    bit          lv;

    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0; lsu_funct3 = 3'd0; lsu_addr_lo = 2'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_dat", reg_wr_dat, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_ready", {31'd0, alu_ready}, 32'd1);
    reset  = 1'b1;
    chk_en = 1'b1;

    // ALU bypass to x5
    step(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd5, 32'h0000_1234, acc);
    chk("byp_we", {31'd0, regWrite}, 32'd1);
    chk("byp_rd", {27'd0, rd}, 32'd5);
    chk("byp_dat", reg_wr_dat, 32'h0000_1234);
    chk("byp_pend", pend_mask, 32'h0000_0020);
    idle();
    chk("byp_pend_clr", pend_mask, 32'd0);

    // LSU wins, ALU queued behind it
    step(1'b1, 5'd6, 32'hDEAD_BEEF, 3'd2, 2'd0, 1'b1, 5'd7, 32'h11, acc);
    chk("mix_rd1", {27'd0, rd}, 32'd6);
    chk("mix_dat1", reg_wr_dat, 32'hDEAD_BEEF);
    chk("mix_pend1", pend_mask, 32'h0000_00C0);
    idle();
    chk("mix_rd2", {27'd0, rd}, 32'd7);
    chk("mix_dat2", reg_wr_dat, 32'h11);
    idle();

    // Load formatting
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd9, 32'h8070_F0FF, t_f3[i], t_lo[i], 1'b0, 5'd0, 32'd0, acc);
      chk($sformatf("load_fmt%0d", i), reg_wr_dat, t_exp[i]);
    end
    idle();

    // Back-to-back loads fill the queue; drain order checked
    ai = 1;
    for (int c = 0; c < 16; c++) begin
      step(c < 4, 5'(10 + c), 32'(32'hA0 + c), 3'd2, 2'd0,
           ai <= 6, 5'(ai), 32'(32'h100 + ai), acc);
      if (acc) ai++;
      if (c == 3) begin
        chk("full_ready", {31'd0, alu_ready}, 32'd0);
        chk("full_acc", 32'(ai), 32'd5);
      end
      if (regWrite) got.push_back(int'(rd));
    end
    chk("drain_len", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk($sformatf("drain%0d", i), 32'(got[i]), 32'(seq_exp[i]));

    // x0 ALU result is consumed without a write
    chk("x0_ready", {31'd0, alu_ready}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, acc);
    chk("x0_we", {31'd0, regWrite}, 32'd0);
    chk("x0_pend", pend_mask, 32'd0);
    idle();
    chk("x0_we2", {31'd0, regWrite}, 32'd0);

    // Async reset with three queued entries
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 5'(20 + c), 32'(c), 3'd2, 2'd0, 1'b1, 5'(c + 1), 32'(32'h200 + c), acc);
    end
    chk("pre_rst_pend", pend_mask, 32'h0040_000E);
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_we", {31'd0, regWrite}, 32'd0);
    chk("arst_pend", pend_mask, 32'd0);
    chk("arst_ready", {31'd0, alu_ready}, 32'd1);
    mq.delete();
    exp_we = 1'b0; exp_rd = 5'd0; exp_dat = 32'd0; exp_pend = 32'd0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (4) idle();
    chk("post_rst_we", {31'd0, regWrite}, 32'd0);

    // Randomized traffic with ALU valid held until accepted
    have = 1'b0; r_ard = 5'd0; r_ad = 32'd0;
    for (int n = 0; n < 600; n++) begin
      lv = ($urandom_range(99, 0) < (((n / 50) % 2 == 0) ? 70 : 15));
      if (!have) begin
        have  = ($urandom_range(2, 0) != 0);
        r_ard = 5'($urandom_range(31, 0));
        r_ad  = $urandom;
      end
      step(lv, 5'($urandom_range(31, 0)), $urandom, 3'($urandom_range(7, 0)),
           2'($urandom_range(3, 0)), have, r_ard, r_ad, acc);
      if (acc) have = 1'b0;
    end
    repeat (6) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage of the RV32I core; the write-side producer for the register-file write port (regWrite, rd, reg_wr_dat).
- Merges results from two sources:
  - ALU, single-cycle, back-pressurable.
  - LSU load responses, never back-pressured.
- Formats load data (byte/half extraction plus sign/zero extension) and issues at most one register write per cycle.
- Exports a pending-write mask that issue logic uses for hazard stalls.

Parameters:
- XLEN, 32, datapath width.
- DEPTH, 4, ALU result queue depth; power of 2, minimum 2.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  queue can accept an ALU result.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  load response valid; always accepted.
- lsu_rd  input  5  load destination register.
- lsu_data  input  XLEN  raw aligned memory word.
- lsu_funct3  input  3  load type.
- lsu_addr_lo  input  2  byte offset of the load address.
- regWrite  output  1  register-file write enable.
- rd  output  5  register-file write index.
- reg_wr_dat  output  XLEN  register-file write data.
- pend_mask  output  32  bit n set when a write to xn is queued or presented.

Behaviour:
- Reset (reset=0, asynchronous): queue count and pointers 0; regWrite=0, rd=0, reg_wr_dat=0.
- Output register:
  - regWrite, rd and reg_wr_dat are registered; a new value is loaded every cycle.
  - regWrite=0 when no source is selected.
- Source selection each cycle, in priority order:
  - 1) lsu_valid=1: the LSU result goes to the output register.
  - 2) Queue non-empty: the queue head is dequeued to the output register.
  - 3) Queue empty and alu_valid & alu_ready: the ALU result bypasses straight to the output register, giving 1-cycle latency.
  - An accepted ALU result not chosen by 3) is enqueued at the tail.
- Accept rules:
  - alu_ready = !full. No enqueue while full, even when a dequeue happens in the same cycle.
  - ALU handshake completes on alu_valid & alu_ready.
- Load formatting, applied before the output register:
  - 000 LB: byte at lsu_addr_lo, sign-extended.
  - 001 LH: half at lsu_addr_lo[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU and 101 LHU: zero-extended.
  - Any other code: treated as LW.
- x0 handling: an x0 result from either source is consumed and its handshake completes, but regWrite stays 0 that cycle. An x0 ALU result is never enqueued.
- pend_mask:
  - Combinational OR of the rd of every valid queue entry, plus rd when regWrite=1.
  - Bit 0 is hard 0.
- Ordering:
  - The issue stage does not dispatch an ALU op whose rd has its pend_mask bit set while a load to that rd is outstanding. WAW across sources is therefore excluded by contract.
  - Within the queue, writes leave in FIFO order.
- Queue arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Simultaneous events:
  - LSU valid, ALU valid, queue empty, not full: the LSU writes and the ALU result is enqueued.
  - Queue full and LSU valid: no dequeue and no enqueue; alu_ready=0.
- Reset mid-operation: queue contents are discarded and regWrite drops immediately (asynchronous).

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: every cycle with regWrite=1 at the clock edge prints "WB WRITE: <data> at x<rd> src=<ALU|LSU|Q>".
- Undefined: no simulation output; RTL is otherwise identical.

Decomposition:
- Package reg_wb_pkg holds:
  - XLEN_DEF.
  - Load funct3 localparams F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Packed struct wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data;}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t, parameter DEPTH, ports push/pop/full/empty/head, plus per-entry valid/rd vectors feeding pend_mask.
- Load formatter stays an internal function in reg_writeback.

Test Plan:
- ALU only, x5=0x0000_1234, queue empty -> next cycle regWrite=1, rd=5, reg_wr_dat=0x0000_1234; pend_mask[5]=1 for exactly that cycle.
- LSU and ALU in the same cycle (LSU x6 LW 0xDEAD_BEEF; ALU x7=0x11) -> cycle 1 writes x6=0xDEAD_BEEF, cycle 2 writes x7=0x11.
- Loads of 0x8070_F0FF:
  - LB, offset 1 -> 0xFFFF_FFF0.
  - LBU, offset 3 -> 0x0000_0080.
  - LH, offset 2 -> 0xFFFF_8070.
  - LHU, offset 0 -> 0x0000_F0FF.
- Four LSU cycles back-to-back while ALU streams x1..x6 -> alu_ready falls after 4 enqueues; drain order is x1..x4, then x5 and x6 are accepted and written in order.
- ALU write to x0 with data 0xFFFF_FFFF -> alu_ready handshake completes, regWrite stays 0, pend_mask=0.
- Assert reset=0 with 3 queued entries -> regWrite=0 and pend_mask=0 immediately; after release, no stale writes appear.
